// File: rtl/unary_window_buffer_writer.sv
// unary_window_buffer_writer: counts ones over LEN valid bits and drives a ping-pong bank select.
// Define UWBW_NOSTALL_EN for an unconditional one-cycle HOLD with a sticky oOverrun flag.
module unary_window_buffer_writer #(
    parameter int LEN  = 16,
    parameter int OWID = $clog2(LEN+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iValid,
    input  logic            iBit,
    output logic            oReady,
    input  logic            iRelease,
    output logic            oSel,
`ifdef UWBW_NOSTALL_EN
    output logic            oOverrun,
`endif
    output logic [OWID-1:0] oData,
    output logic            oSwap
);
    localparam int VW = $clog2(LEN);
    typedef enum logic {ACC, HOLD} state_t;
    state_t          r_state;
    logic [OWID-1:0] r_cnt;
    logic [OWID-1:0] r_data;
    logic [VW-1:0]   r_vcnt;
    logic            r_ready;
    logic            r_sel;
    logic            r_swap;
    logic            r_overrun;
    logic            w_take;
    logic            w_last;
    logic            w_swap;
    assign w_take = iValid & r_ready;
    assign w_last = r_vcnt == VW'(LEN-1);
`ifdef UWBW_NOSTALL_EN
    assign w_swap   = 1'b1;
    assign oOverrun = r_overrun;
`else
    assign w_swap   = iRelease;
`endif
    assign oReady = r_ready;
    assign oSel   = r_sel;
    assign oData  = r_data;
    assign oSwap  = r_swap;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ACC;
            r_cnt     <= '0;
            r_vcnt    <= '0;
            r_data    <= '0;
            r_ready   <= 1'b1;
            r_sel     <= 1'b0;
            r_swap    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_swap <= 1'b0;
            if (r_state == ACC) begin
                if (w_take && w_last) begin
                    r_data  <= r_cnt + OWID'(iBit);
                    r_cnt   <= '0;
                    r_vcnt  <= '0;
                    r_ready <= 1'b0;
                    r_state <= HOLD;
                end else if (w_take) begin
                    r_cnt  <= r_cnt + OWID'(iBit);
                    r_vcnt <= r_vcnt + VW'(1);
                end
            end else if (w_swap) begin
                // the bank being released is the one we load next, so toggle only now
                r_sel     <= ~r_sel;
                r_swap    <= 1'b1;
                r_ready   <= 1'b1;
                r_state   <= ACC;
                r_overrun <= r_overrun | ~iRelease;
            end
        end
    end
endmodule
